// File: rtl/gesture_event_synth.sv
// Synthetic event-camera gesture stream: a 2x2 pixel cluster walks in one direction.
// Define GESTURE_SYNTH_NOISE_EN to add LFSR position jitter and random polarity.
module gesture_event_synth #(
    parameter int X_BITS          = 7,
    parameter int Y_BITS          = 7,
    parameter int START_X         = 64,
    parameter int START_Y         = 64,
    parameter int NUM_STEPS       = 8,
    parameter int EVENTS_PER_STEP = 4,
    parameter int STEP_PIXELS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_gesture,
    input  logic              abort,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [X_BITS-1:0] ev_x,
    output logic [Y_BITS-1:0] ev_y,
    output logic              ev_polarity,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam int X_MAX = (1 << X_BITS) - 1;
    localparam int Y_MAX = (1 << Y_BITS) - 1;

    state_t            state_q, state_d;
    logic [1:0]        gesture_q, gesture_d;
    logic [X_BITS-1:0] pos_x_q, pos_x_d;
    logic [Y_BITS-1:0] pos_y_q, pos_y_d;
    logic [7:0]        step_q, step_d;
    logic [7:0]        evt_q, evt_d;
    logic              handshake;
    int                jit_x, jit_y;
    logic              pol_raw;

    function automatic logic [X_BITS-1:0] sat_x(input int v);
        if (v < 0)          return '0;
        else if (v > X_MAX) return '1;
        else                return v[X_BITS-1:0];
    endfunction

    function automatic logic [Y_BITS-1:0] sat_y(input int v);
        if (v < 0)          return '0;
        else if (v > Y_MAX) return '1;
        else                return v[Y_BITS-1:0];
    endfunction

    // abort wins over a handshake in the same cycle
    assign handshake = (state_q == EMIT) && ev_ready && !abort;

`ifdef GESTURE_SYNTH_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (handshake) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    assign jit_x   = int'(lfsr_q[0]);
    assign jit_y   = int'(lfsr_q[1]);
    assign pol_raw = lfsr_q[2];
`else
    assign jit_x   = 0;
    assign jit_y   = 0;
    assign pol_raw = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        gesture_d = gesture_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        step_d    = step_q;
        evt_d     = evt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    gesture_d = cmd_gesture;
                    pos_x_d   = sat_x(START_X);
                    pos_y_d   = sat_y(START_Y);
                    step_d    = '0;
                    evt_d     = '0;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    if (evt_q == 8'(EVENTS_PER_STEP - 1)) begin
                        evt_d = '0;
                        if (step_q == 8'(NUM_STEPS - 1)) begin
                            state_d = DONE;
                        end else begin
                            step_d = step_q + 8'd1;
                            unique case (gesture_q)
                                2'b00: pos_y_d = sat_y(int'(pos_y_q) - STEP_PIXELS);
                                2'b01: pos_y_d = sat_y(int'(pos_y_q) + STEP_PIXELS);
                                2'b10: pos_x_d = sat_x(int'(pos_x_q) - STEP_PIXELS);
                                2'b11: pos_x_d = sat_x(int'(pos_x_q) + STEP_PIXELS);
                                default: ;
                            endcase
                        end
                    end else begin
                        evt_d = evt_q + 8'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gesture_q <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            step_q    <= '0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gesture_q <= gesture_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            step_q    <= step_d;
            evt_q     <= evt_d;
        end
    end

    // Event fields are derived from registered state, so they hold through stalls
    assign ev_valid    = (state_q == EMIT);
    assign ev_x        = ev_valid ? sat_x(int'(pos_x_q) + int'(evt_q[0]) + jit_x) : '0;
    assign ev_y        = ev_valid ? sat_y(int'(pos_y_q) + int'(evt_q[1]) + jit_y) : '0;
    assign ev_polarity = ev_valid ? pol_raw : 1'b0;
    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q == EMIT);
    assign done        = (state_q == DONE);
endmodule

// File: doc/gesture_event_synth.md
GESTURE_EVENT_SYNTH -- requirements
Module: gesture_event_synth

Interface
REQ-001 SHALL have parameter X_BITS, default 7, event X coordinate width (sensor columns 0..2^X_BITS-1).
REQ-002 SHALL have parameter Y_BITS, default 7, event Y coordinate width.
REQ-003 SHALL have parameter START_X, default 64, trajectory start column.
REQ-004 SHALL have parameter START_Y, default 64, trajectory start row.
REQ-005 SHALL have parameter NUM_STEPS, default 8, trajectory steps per gesture (1..255).
REQ-006 SHALL have parameter EVENTS_PER_STEP, default 4, events per step (1..255).
REQ-007 SHALL have parameter STEP_PIXELS, default 2, per-step displacement in pixels.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-009 SHALL have ports: cmd_valid in 1 command offered; cmd_ready out 1 command accepted when high with cmd_valid; cmd_gesture in 2 gesture code (00 UP, 01 DOWN, 10 LEFT, 11 RIGHT).
REQ-010 SHALL have ports: abort in 1 cancel the active stream.
REQ-011 SHALL have ports: ev_valid out 1 event offered; ev_ready in 1 downstream accepts; ev_x out X_BITS; ev_y out Y_BITS; ev_polarity out 1.
REQ-012 SHALL have ports: busy out 1 stream active; done out 1 single-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> EMIT -> DONE -> IDLE; cmd_ready = 1 only in IDLE; busy = 1 only in EMIT.
REQ-014 SHALL, on cmd_valid && cmd_ready, latch cmd_gesture, set pos = (START_X, START_Y), clear step/event counters, and enter EMIT; ev_valid first asserts the next cycle.
REQ-015 SHALL, in EMIT, drive ev_valid = 1 with event k of the current step at x = sat(pos_x + k[0]), y = sat(pos_y + k[1]) (2x2 cluster), ev_polarity = 1.
REQ-016 SHALL hold ev_x, ev_y, ev_polarity stable while ev_valid && !ev_ready; advance to the next event only on the ev_valid && ev_ready handshake.
REQ-017 SHALL support one event per cycle under continuous ev_ready = 1, with no bubbles between steps.
REQ-018 SHALL, after the handshake of event EVENTS_PER_STEP-1, move pos by STEP_PIXELS: UP y-, DOWN y+, LEFT x-, RIGHT x+.
REQ-019 SHALL saturate every coordinate to [0, 2^BITS-1], with no wrap-around, for both pos updates and cluster offsets.
REQ-020 SHALL, after the handshake of the final event (step NUM_STEPS-1, event EVENTS_PER_STEP-1), enter DONE; ev_valid = 0 and done = 1 for exactly that one cycle, then return to IDLE.
REQ-021 SHALL, on abort = 1 in EMIT, return to IDLE the next cycle with ev_valid = 0 and no done pulse; abort has priority over a same-cycle handshake; abort in IDLE or DONE is ignored.
REQ-022 SHALL ignore cmd_valid outside IDLE; commands are never queued.
REQ-023 SHALL produce NUM_STEPS*EVENTS_PER_STEP events whose first-to-last step displacement on the dominant axis is (NUM_STEPS-1)*STEP_PIXELS, unless saturated.

Reset
REQ-024 SHALL, on rst, enter IDLE and drive cmd_ready = 1 from the following cycle; ev_valid, busy, done = 0; ev_x, ev_y, ev_polarity = 0; counters = 0.
REQ-025 SHALL let rst mid-stream discard the stream, with no done pulse and no further events.

Configuration
REQ-026 SHALL, with macro GESTURE_SYNTH_NOISE_EN defined, include a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) that advances on each handshake; lfsr[1:0] adds jitter of 0 or +1 to x and y (before saturation), and ev_polarity = lfsr[2].
REQ-027 SHALL, without GESTURE_SYNTH_NOISE_EN, contain no LFSR and produce a fully deterministic output per REQ-015.

Verification
REQ-028 SHALL cover: defaults, RIGHT, ev_ready = 1 -> 32 contiguous events; ev0 (64,64); ev4 (66,64); ev31 (79,65); done one cycle after ev31.
REQ-029 SHALL cover: UP, ev_ready toggling 1/0 -> outputs stable during stalls; step-7 cluster rows 50/51; still 32 events.
REQ-030 SHALL cover: START_X = 124, RIGHT -> x saturates at 127 from step 2 onward, with no wrap to 0.
REQ-031 SHALL cover: cmd_valid pulsed during EMIT -> ignored (cmd_ready = 0); stream continues unchanged.
REQ-032 SHALL cover: abort after ev10 handshake (abort same cycle as ev11 handshake) -> ev_valid = 0 next cycle, no done, cmd_ready = 1.
REQ-033 SHALL cover: rst asserted at ev5 -> all outputs at reset values; a new LEFT command then starts at (64,64).
